// File: rtl/f11_qbus_pkg.sv
// Purpose: shared Q-bus definitions for the F-11 board model (slave FSM states, widths, strobe indices).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package f11_qbus_pkg;

  // Full Q-bus byte-address width (22-bit physical space).
  localparam int QB_AW = 22;

  // Processor bus timer: a cycle with no RPLY after this many clocks is aborted.
  localparam int QB_TMO = 64;

  // Largest wait-state count a slave may insert and still reply well inside the bus timer.
  localparam int QB_WAIT_MAX = 40;

  // Bit positions in the de-inverted strobe vector {iako, wtbt, dout, din, sync}.
  localparam int ST_SYNC = 0;
  localparam int ST_DIN  = 1;
  localparam int ST_DOUT = 2;
  localparam int ST_WTBT = 3;
  localparam int ST_IAKO = 4;
  localparam int ST_N    = 5;

  // Slave cycle states.
  typedef enum logic [2:0] {
    QS_IDLE  = 3'd0,
    QS_SEL   = 3'd1,
    QS_WAIT  = 3'd2,
    QS_REPLY = 3'd3,
    QS_HOLD  = 3'd4
  } qs_t;

endpackage

// File: rtl/f11_qmem_ram.sv
// Purpose: single-port word RAM with per-byte write enables backing the Q-bus memory.
// Latency: read data registered, valid after the enabling edge; writes land on the enabling edge.
// Backpressure: none; one access per enabled clock, rdata holds until the next read.
module f11_qmem_ram #(
  parameter int AW = 13
) (
  input  logic          pin_clk,
  input  logic          en,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  // Byte-lane writes, or a registered read when no lane is being written.
  always_ff @(posedge pin_clk) begin
    if (en) begin
      if (we[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we[1]) mem[addr][15:8] <= wdata[15:8];
      if (we == 2'b00) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/f11_qmem.sv
// Purpose: Q-bus slave memory serving DATI/DATO(B)/DATIO(B) from an internal word array on the F-11 pins.
// Latency: RPLY and read data valid WAIT_CYC+1 clocks after the edge that samples DIN/DOUT.
// Backpressure: holds RPLY until the master negates its strobe; a strobe dropped during wait states aborts silently.
module f11_qmem
  import f11_qbus_pkg::*;
#(
  parameter logic [QB_AW-1:0] BASE     = 22'o0,
  parameter int               AW       = 13,
  parameter int               WAIT_CYC = 2
) (
  input  logic       pin_clk,
  input  logic       pin_dclo_n,
  inout  wire [15:0] pin_ad_n,
  input  logic [5:0] pin_a_n,
  input  logic       pin_bs_n,
  input  logic       pin_sync_n,
  input  logic       pin_din_n,
  input  logic       pin_dout_n,
  input  logic       pin_wtbt_n,
  input  logic       pin_iako_n,
  output wire        pin_rply_n
);

  // Parameter sanity: the array must fit under the 22-bit space with at least one
  // compared base bit, and the wait count must leave the reply inside the bus timer.
  if (AW < 1 || AW > QB_AW - 2) begin : g_bad_aw
    $error("f11_qmem: AW out of range");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > QB_WAIT_MAX || WAIT_CYC + 2 >= QB_TMO) begin : g_bad_wait
    $error("f11_qmem: WAIT_CYC out of range for the processor bus timer");
  end

  localparam logic [5:0] WAIT_INIT = 6'(WAIT_CYC);

  // De-inverted pin view.
  logic [ST_N-1:0]  strb;
  logic             sync, din, dout, wtbt, iako, bs;
  logic [QB_AW-1:0] bus_addr;
  logic             hit;

  assign strb     = ~{pin_iako_n, pin_wtbt_n, pin_dout_n, pin_din_n, pin_sync_n};
  assign sync     = strb[ST_SYNC];
  assign din      = strb[ST_DIN];
  assign dout     = strb[ST_DOUT];
  assign wtbt     = strb[ST_WTBT];
  assign iako     = strb[ST_IAKO];
  assign bs       = ~pin_bs_n;
  assign bus_addr = ~{pin_a_n, pin_ad_n};
  // Only the bits above the array index take part in the decode; the I/O page never selects.
  assign hit      = !bs && ((bus_addr >> (AW + 1)) == (BASE >> (AW + 1)));

  qs_t        state_q, state_d;
  logic [5:0] wcnt_q, wcnt_d;
  // Only the in-array part of the address is kept; the upper bits matter solely at decode time.
  logic [AW:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wtbt_q, wtbt_d;
  logic        sync_q, din_q, dout_q;
  logic        rply_q, ad_oe_q;
  logic        go_rd, go_wr;
  logic        ram_en;
  logic [1:0]  ram_we;
  logic [15:0] ram_rdata;

  // Next-state, wait counter, and RAM strobes for the slave cycle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wtbt_d  = wtbt_q;
    go_rd   = 1'b0;
    go_wr   = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 2'b00;
    case (state_q)
      QS_IDLE: begin
        // Latch only on the SYNC leading edge; a deselected cycle is then ignored until SYNC drops.
        if (sync && !sync_q) begin
          addr_d = bus_addr[AW:0];
          if (hit) state_d = QS_SEL;
        end
      end
      QS_SEL: begin
        if (!sync) begin
          state_d = QS_IDLE;
        end else if (!iako) begin
          go_rd = din;
          go_wr = dout && !din;
        end
      end
      QS_WAIT: begin
        if (rd_q ? !din : !dout) begin
          state_d = QS_SEL;
        end else if (wcnt_q == 6'd0) begin
          state_d = QS_REPLY;
          if (!rd_q) begin
            ram_en = 1'b1;
            ram_we = wtbt_q ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
          end
        end else begin
          wcnt_d = wcnt_q - 6'd1;
        end
      end
      QS_REPLY: begin
        if (rd_q ? !din : !dout) state_d = QS_HOLD;
      end
      QS_HOLD: begin
        // Second half of DATIO needs a fresh strobe edge, so a DOUT left asserted
        // across a DIN is not mistaken for a new request.
        if (!sync) begin
          state_d = QS_IDLE;
        end else if (!iako) begin
          go_rd = din && !din_q;
          go_wr = dout && !dout_q && !din;
        end
      end
      default: state_d = QS_IDLE;
    endcase
    if (go_rd || go_wr) begin
      state_d = QS_WAIT;
      wcnt_d  = WAIT_INIT;
      rd_d    = go_rd;
      wtbt_d  = wtbt;
      ram_en  = go_rd;
    end
  end

  // FSM and pin-driver registers; drivers stay on for one clock after REPLY so
  // release follows the strobe negation by a full clock.
  always_ff @(posedge pin_clk) begin
    if (!pin_dclo_n) begin
      state_q <= QS_IDLE;
      wcnt_q  <= 6'd0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wtbt_q  <= 1'b0;
      rply_q  <= 1'b0;
      ad_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wtbt_q  <= wtbt_d;
      rply_q  <= (state_d == QS_REPLY) || (state_q == QS_REPLY);
      ad_oe_q <= rd_q && ((state_d == QS_REPLY) || (state_q == QS_REPLY));
    end
  end

  // Previous-clock strobe samples for edge detection; kept live through reset so a
  // SYNC still asserted at reset release is not seen as a new cycle.
  always_ff @(posedge pin_clk) begin
    sync_q <= sync;
    din_q  <= din;
    dout_q <= dout;
  end

  // Reset on the same edge cancels any write the FSM would otherwise commit.
  f11_qmem_ram #(
    .AW(AW)
  ) u_ram (
    .pin_clk (pin_clk),
    .en      (ram_en & pin_dclo_n),
    .we      (ram_we & {2{pin_dclo_n}}),
    .addr    (addr_q[AW:1]),
    .wdata   (~pin_ad_n),
    .rdata   (ram_rdata)
  );

  assign pin_rply_n = rply_q ? 1'b0 : 1'bz;
  assign pin_ad_n   = ad_oe_q ? ~ram_rdata : {16{1'bz}};

endmodule

// File: tb/tb_f11_qmem.sv
module tb_f11_qmem;

  logic       clk = 1'b0;
  logic       dclo_n, sync_n, din_n, dout_n, wtbt_n, iako_n, bs_n;
  logic [5:0] a_n;
  logic [15:0] ad_drv;
  logic       ad_oe;

  tri1 [15:0] ad0;
  tri1 [15:0] ad1;
  tri1        rply0;
  tri1        rply1;

  assign ad0 = ad_oe ? ad_drv : 16'bz;
  assign ad1 = ad_oe ? ad_drv : 16'bz;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory at 0..037777, two wait states.
  f11_qmem #(.BASE(22'o0), .AW(13), .WAIT_CYC(2)) u_dut (
    .pin_clk(clk), .pin_dclo_n(dclo_n), .pin_ad_n(ad0), .pin_a_n(a_n), .pin_bs_n(bs_n),
    .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n), .pin_wtbt_n(wtbt_n),
    .pin_iako_n(iako_n), .pin_rply_n(rply0)
  );

  // Memory at 0200000..0237777, ten wait states.
  f11_qmem #(.BASE(22'o200000), .AW(13), .WAIT_CYC(10)) u_dut10 (
    .pin_clk(clk), .pin_dclo_n(dclo_n), .pin_ad_n(ad1), .pin_a_n(a_n), .pin_bs_n(bs_n),
    .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n), .pin_wtbt_n(wtbt_n),
    .pin_iako_n(iako_n), .pin_rply_n(rply1)
  );

  function automatic bit rply_on();
    return (rply0 == 1'b0) || (rply1 == 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [21:0] a, input bit bs);
    a_n    = ~a[21:16];
    ad_drv = ~a[15:0];
    ad_oe  = 1'b1;
    bs_n   = ~bs;
    sync_n = 1'b0;
    tick();
    ad_oe  = 1'b0;
    a_n    = 6'h3f;
    bs_n   = 1'b1;
  endtask

  // lat = edges after the strobe-sampling edge until RPLY is seen; -1 on bus timeout.
  task automatic wait_rply(output int lat, output logic [15:0] rdat);
    lat  = -1;
    rdat = 16'h0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (rply_on()) begin
        lat  = i;
        rdat = ~(ad0 & ad1);
        break;
      end
    end
  endtask

  task automatic strobe(input bit rd, input bit bytew, input logic [15:0] wd,
                        output int lat, output logic [15:0] rdat, output bit on_m, output bit on_m1);
    wtbt_n = ~bytew;
    if (!rd) begin
      ad_drv = ~wd;
      ad_oe  = 1'b1;
    end
    if (rd) din_n = 1'b0;
    else    dout_n = 1'b0;
    wait_rply(lat, rdat);
    din_n  = 1'b1;
    dout_n = 1'b1;
    tick();
    on_m = rply_on();
    tick();
    on_m1  = rply_on();
    ad_oe  = 1'b0;
    wtbt_n = 1'b1;
  endtask

  task automatic end_cycle();
    sync_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic dati(input logic [21:0] a, input bit bs, output int lat, output logic [15:0] rdat);
    bit m, m1;
    addr_phase(a, bs);
    strobe(1'b1, 1'b0, 16'h0, lat, rdat, m, m1);
    end_cycle();
  endtask

  task automatic dato(input logic [21:0] a, input bit bytew, input logic [15:0] wd, output int lat);
    bit m, m1;
    logic [15:0] rdat;
    addr_phase(a, 1'b0);
    strobe(1'b0, bytew, wd, lat, rdat, m, m1);
    end_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          cnt;
    logic [15:0] rd;
    bit          m, m1;

    dclo_n = 1'b0; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1; wtbt_n = 1'b1;
    iako_n = 1'b1; bs_n = 1'b1; a_n = 6'h3f; ad_drv = 16'hffff; ad_oe = 1'b0;
    repeat (3) tick();

    // Reset state: everything released.
    chk("rst_rply", rply_on(), 1'b0);
    chk("rst_ad0", ad0, 16'hffff);
    chk("rst_ad1", ad1, 16'hffff);
    dclo_n = 1'b1;
    tick();

    // Word write then read at 001000.
    dato(22'o001000, 1'b0, 16'o012345, lat);
    chk("wr_lat", lat, 3);
    addr_phase(22'o001000, 1'b0);
    strobe(1'b1, 1'b0, 16'h0, lat, rd, m, m1);
    end_cycle();
    chk("rd_lat", lat, 3);
    chk("rd_dat", rd, 16'o012345);
    chk("rd_rply_at_m", m, 1'b1);
    chk("rd_rply_at_m1", m1, 1'b0);

    // Odd byte write.
    dato(22'o001001, 1'b1, 16'o177000, lat);
    chk("wrb_hi_lat", lat, 3);
    dati(22'o001000, 1'b0, lat, rd);
    chk("rdb_hi_dat", rd, 16'o177345);

    // Even byte write.
    dato(22'o001000, 1'b1, 16'h0052, lat);
    dati(22'o001000, 1'b0, lat, rd);
    chk("rdb_lo_dat", rd, 16'hfe52);

    // Not selected: out of range, I/O page, BS on an in-range address.
    dati(22'o100000, 1'b0, lat, rd);
    chk("oor_norply", lat, -1);
    dati(22'o177560, 1'b1, lat, rd);
    chk("iopage_norply", lat, -1);
    dati(22'o001000, 1'b1, lat, rd);
    chk("bs_norply", lat, -1);

    // Interrupt acknowledge is never replied to.
    addr_phase(22'o001000, 1'b0);
    iako_n = 1'b0;
    strobe(1'b1, 1'b0, 16'h0, lat, rd, m, m1);
    iako_n = 1'b1;
    end_cycle();
    chk("iako_norply", lat, -1);

    // DATIO under one SYNC.
    dato(22'o002000, 1'b0, 16'o000007, lat);
    addr_phase(22'o002000, 1'b0);
    strobe(1'b1, 1'b0, 16'h0, lat, rd, m, m1);
    chk("datio_rd_lat", lat, 3);
    chk("datio_rd_dat", rd, 16'o000007);
    strobe(1'b0, 1'b0, 16'o000010, lat, rd, m, m1);
    chk("datio_wr_lat", lat, 3);
    end_cycle();
    dati(22'o002000, 1'b0, lat, rd);
    chk("datio_readback", rd, 16'o000010);

    // Reset while replying to a DIN.
    addr_phase(22'o001000, 1'b0);
    din_n = 1'b0;
    wait_rply(lat, rd);
    chk("rstmid_lat", lat, 3);
    dclo_n = 1'b0;
    tick();
    chk("rstmid_rply", rply_on(), 1'b0);
    chk("rstmid_ad", ad0, 16'hffff);
    din_n  = 1'b1;
    sync_n = 1'b1;
    tick();
    dclo_n = 1'b1;
    tick();
    tick();
    dati(22'o001000, 1'b0, lat, rd);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_dat", rd, 16'hfe52);

    // Ten wait states, then an aborted write.
    dato(22'o200100, 1'b0, 16'h1234, lat);
    chk("w10_lat", lat, 11);
    addr_phase(22'o200100, 1'b0);
    ad_drv = ~16'h5555;
    ad_oe  = 1'b1;
    dout_n = 1'b0;
    repeat (3) tick();
    dout_n = 1'b1;
    ad_oe  = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick();
      if (rply_on()) cnt++;
    end
    chk("abort_norply", cnt, 0);
    end_cycle();
    dati(22'o200100, 1'b0, lat, rd);
    chk("abort_rd_lat", lat, 11);
    chk("abort_mem", rd, 16'h1234);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/f11_qmem.md
# f11_qmem

Q-bus slave memory for the F-11 processor board model. It decodes the inverted 22-bit address the processor presents under SYNC and serves DATI, DATO(B) and DATIO(B) cycles from an internal word array. It replies on the open-drain RPLY line after a programmable number of wait states. It attaches directly to the processor's external pins (`pin_ad_n`, `pin_a_n`, `pin_bs_n`, strobes) and is the first consumer of the bus transactions the processor wrapper issues.

## Interface
- `BASE`, default 22'o0: first byte address served; must be aligned to 2^(AW+1).
- `AW`, default 13: word-address width; the array holds 2^AW words, 8K words by default.
- `WAIT_CYC`, default 2: wait clocks inserted before RPLY; legal range 0..40. The processor's bus timer aborts a cycle after 64 clocks.

- `pin_clk` — input, 1 — the single clock; all state changes on its rising edge.
- `pin_dclo_n` — input, 1 — synchronous, active-low reset.
- `pin_ad_n` — inout, 16 — inverted multiplexed address/data.
- `pin_a_n` — input, 6 — inverted address bits 21:16.
- `pin_bs_n` — input, 1 — inverted I/O bank select.
- `pin_sync_n`, `pin_din_n`, `pin_dout_n`, `pin_wtbt_n`, `pin_iako_n` — input, 1 each — inverted bus strobes.
- `pin_rply_n` — output, 1 — open drain: drives 0 or Z.

## Operation
- States: IDLE, SEL, WAIT, REPLY, HOLD.
- **IDLE**
  - On the first clock where SYNC is sampled asserted and was deasserted on the previous clock, latch `addr[21:0]` = ~{`pin_a_n`, `pin_ad_n`} and `bs` = ~`pin_bs_n`.
  - Selected iff `bs`=0 and `addr[21:AW+1]` == `BASE[21:AW+1]`. Selected → SEL; otherwise stay in IDLE and ignore the cycle until SYNC negates.
- **SEL**
  - DIN or DOUT sampled asserted while IAKO is deasserted → WAIT, with `wcnt`=`WAIT_CYC`.
  - SYNC negated → IDLE.
  - IAKO: never replied to.
- **WAIT**
  - Decrement `wcnt`; at `wcnt`==0 → REPLY.
  - Read operation: the memory read is issued on entry to WAIT.
- **REPLY**
  - Assert RPLY.
  - DIN: drive `pin_ad_n` = ~`rdata`.
  - DOUT: commit the write on the REPLY entry clock, exactly once per strobe.
    - WTBT sampled asserted at the DOUT edge means byte write: lane = `addr[0]` (0 → bits 7:0, 1 → bits 15:8), data taken from the matching half of ~`pin_ad_n`.
    - Otherwise word write; `addr[0]` ignored.
  - Stay until the active strobe is sampled negated → HOLD.
- **HOLD**
  - Release RPLY and bus drivers.
  - New DIN/DOUT under the same SYNC (second half of DATIO) → WAIT.
  - SYNC negated → IDLE.
- Word address = `addr[AW:1]`; no wrap inside the array, since out-of-range addresses never select.
- DIN and DOUT both asserted: treated as DIN; DOUT is not serviced until the next strobe edge.
- Reset (`pin_dclo_n`=0 on a clock edge): state=IDLE, RPLY released, `pin_ad_n`=Z, `wcnt`=0, latched `addr`=0, any pending write discarded. The memory array is not cleared.
- Strobe negated during WAIT (processor abort): return to SEL with no write and no reply.

## Timing
- Reset values: `pin_rply_n`=Z, `pin_ad_n`=Z.
- DIN/DOUT sampled asserted at edge N → RPLY and read data valid after edge N+1+`WAIT_CYC`. Read data and RPLY go valid on the same edge.
- Strobe sampled negated at edge M → RPLY and data released after edge M+1.
- Address latch: the single clock where SYNC is first sampled asserted; `pin_ad_n` later in the cycle is not re-latched.
- Write lands in the array at the REPLY entry edge; it is readable by a DIN in the next bus cycle.
- Minimum DATI cycle with `WAIT_CYC`=0: RPLY 1 clock after DIN.

## Structure
- Package `f11_qbus_pkg`:
  - state enum `qs_t`
  - `QB_AW`=22
  - strobe index constants
  - `QB_TMO`=64, the processor bus-timer limit, used in the `WAIT_CYC` range assertion
- Sub-module `f11_qmem_ram`: single-port, synchronous read, two byte-write enables, depth 2^AW × 16.
- Top holds the FSM, address latch, wait counter and tristate/open-drain pin logic.

## Test plan
- Word read: preload word 012345 at 001000; DATI 001000 → RPLY 3 clocks after DIN (`WAIT_CYC`=2), `pin_ad_n`=~012345.
- Odd byte write: DATOB 001001 with data 0177000 and WTBT asserted → read-back of 001000 gives 0177345.
- Out of range / I/O page: DATI 0100000 with `AW`=13 → no RPLY. DATI 177560 with BS asserted → no RPLY, and the processor times out at 64 clocks.
- DATIO: one SYNC, DIN reads 000007, then DOUT writes 000010 → two replies; read-back gives 000010.
- Reset mid-cycle: `pin_dclo_n` low during REPLY of a DIN → RPLY and `pin_ad_n` are Z after that edge; the next cycle after release works normally.
- Abort: DOUT negated during WAIT with `WAIT_CYC`=10 → no RPLY and memory unchanged.
